// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer and the decode_op_imm decoder family:
// microcycle codes, trap cause codes and the NOP instruction encoding.
package fetch_sequencer_pkg;

  localparam logic [2:0] CYC_0 = 3'd0;
  localparam logic [2:0] CYC_1 = 3'd1;
  localparam logic [2:0] CYC_2 = 3'd2;
  localparam logic [2:0] CYC_3 = 3'd3;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS   = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;

  // ADDI X0,X0,0
  localparam logic [31:0] IR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: trap-vector load, jump load and +4 increment, in that
// priority, plus the word-misalignment flag used to raise fetch traps.
module fetch_pc_reg #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_0100,
  parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        vec_i,
  input  logic        ld_i,
  input  logic [63:0] ld_dat_i,
  input  logic        inc_i,
  output logic [63:0] pc_o,
  output logic        misalign_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     pc_o <= RESET_PC;
    else if (vec_i)  pc_o <= TRAP_VECTOR;
    else if (ld_i)   pc_o <= ld_dat_i;
    else if (inc_i)  pc_o <= pc_o + 64'd4;
  end

  assign misalign_o = (pc_o[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch master, IR/IPC and microcycle register feeding the decoders,
// with illegal-instruction and misaligned-fetch traps. FETCH_BUSERR_EN adds
// the fetch access-fault trap on ierr_i.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_0100,
  parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_IR      = IR_NOP
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [63:0] iadr_o,
  output logic        icyc_o,
  output logic        istb_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  input  logic        ierr_i,
  output logic [31:0] ir_o,
  output logic [2:0]  cstate_o,
  input  logic [2:0]  nstate_i,
  input  logic        ir_dat_irl_i,
  input  logic        defined_i,
  input  logic        pc_ld_i,
  input  logic [63:0] pc_dat_i,
  output logic        ack_o,
  output logic        trap_o,
  output logic [63:0] epc_o,
  output logic [3:0]  cause_o,
  output logic [63:0] ipc_o
);

  logic [63:0] pc;
  logic        misalign_pc;
  logic        illegal;
  logic        misalign;
  logic        fetch_req;
  logic        fetch_done;
  logic        stall;
  logic        buserr;

  fetch_pc_reg #(
    .RESET_PC    (RESET_PC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .vec_i      (trap_o),
    .ld_i       (pc_ld_i && !stall),
    .ld_dat_i   (pc_dat_i),
    .inc_i      (fetch_done),
    .pc_o       (pc),
    .misalign_o (misalign_pc)
  );

  assign illegal   = !defined_i;
  assign misalign  = ir_dat_irl_i && misalign_pc && !illegal;
  assign fetch_req = ir_dat_irl_i && !misalign_pc && !illegal;

`ifdef FETCH_BUSERR_EN
  assign buserr = fetch_req && ierr_i;
`else
  logic unused_ierr;
  assign unused_ierr = ierr_i;
  assign buserr      = 1'b0;
`endif

  assign trap_o     = illegal || misalign || buserr;
  assign fetch_done = fetch_req && iack_i && !buserr;
  assign stall      = fetch_req && !iack_i && !buserr;

  // Fetch handshake: icyc_o/istb_o stay high from the request until the cycle
  // iack_i (or ierr_i) is sampled high; idat_i is taken only in that cycle, and
  // decoders see the same completion on ack_o so they advance in lockstep.
  assign iadr_o = pc;
  assign icyc_o = fetch_req && !reset_i;
  assign istb_o = fetch_req && !reset_i;
  assign ack_o  = fetch_req ? iack_i : 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ir_o     <= NOP_IR;
      ipc_o    <= RESET_PC;
      cstate_o <= CYC_3;
      epc_o    <= 64'd0;
      cause_o  <= CAUSE_MISALIGN;
    end else if (illegal) begin
      epc_o    <= ipc_o;
      cause_o  <= CAUSE_ILLEGAL;
      ir_o     <= NOP_IR;
      cstate_o <= CYC_3;
    end else if (misalign) begin
      epc_o    <= pc;
      cause_o  <= CAUSE_MISALIGN;
      ir_o     <= NOP_IR;
      cstate_o <= CYC_3;
    end else if (buserr) begin
      // IR keeps the previous word; cycle 3 re-requests a fetch from the vector.
      epc_o    <= pc;
      cause_o  <= CAUSE_ACCESS;
      cstate_o <= CYC_3;
    end else if (fetch_done) begin
      ir_o     <= idat_i;
      ipc_o    <= pc;
      cstate_o <= nstate_i;
    end else if (!stall) begin
      cstate_o <= nstate_i;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, wait states, traps, jump during
// fetch, PC wrap, bus error (build-dependent) and asynchronous reset mid-fetch.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_o;
  logic        icyc_o, istb_o;
  logic        iack_i;
  logic [31:0] idat_i;
  logic        ierr_i;
  logic [31:0] ir_o;
  logic [2:0]  cstate_o;
  logic [2:0]  nstate_i;
  logic        ir_dat_irl_i, defined_i, pc_ld_i;
  logic [63:0] pc_dat_i;
  logic        ack_o, trap_o;
  logic [63:0] epc_o;
  logic [3:0]  cause_o;
  logic [63:0] ipc_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .iadr_o       (iadr_o),
    .icyc_o       (icyc_o),
    .istb_o       (istb_o),
    .iack_i       (iack_i),
    .idat_i       (idat_i),
    .ierr_i       (ierr_i),
    .ir_o         (ir_o),
    .cstate_o     (cstate_o),
    .nstate_i     (nstate_i),
    .ir_dat_irl_i (ir_dat_irl_i),
    .defined_i    (defined_i),
    .pc_ld_i      (pc_ld_i),
    .pc_dat_i     (pc_dat_i),
    .ack_o        (ack_o),
    .trap_o       (trap_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o),
    .ipc_o        (ipc_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // advance one clock; inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic irl, input logic [2:0] ns, input logic ack,
                       input logic [31:0] dat, input logic def);
    ir_dat_irl_i = irl;
    nstate_i     = ns;
    iack_i       = ack;
    idat_i       = dat;
    defined_i    = def;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; iack_i = 1'b0; idat_i = 32'd0; ierr_i = 1'b0;
    nstate_i = 3'd3; ir_dat_irl_i = 1'b0; defined_i = 1'b1;
    pc_ld_i = 1'b0; pc_dat_i = 64'd0;
    repeat (3) tick();

    // reset state
    check("rst_iadr",   iadr_o,   64'h100);
    check("rst_cstate", cstate_o, 3);
    check("rst_ir",     ir_o,     32'h0000_0013);
    check("rst_icyc",   icyc_o,   0);
    check("rst_trap",   trap_o,   0);
    check("rst_epc",    epc_o,    0);
    check("rst_cause",  cause_o,  0);
    check("rst_ipc",    ipc_o,    64'h100);
    reset_i = 1'b0;

    // zero-wait-state fetch from the NOP's cycle 3
    drive(1, 0, 1, 32'h0420_0093, 1);
    check("f0_icyc", icyc_o, 1);
    check("f0_istb", istb_o, 1);
    check("f0_ack",  ack_o,  1);
    tick();
    check("f0_ir",     ir_o,     32'h0420_0093);
    check("f0_ipc",    ipc_o,    64'h100);
    check("f0_pc",     iadr_o,   64'h104);
    check("f0_cstate", cstate_o, 0);

    // normal advance without fetch
    drive(0, 3, 0, 32'd0, 1);
    check("adv_icyc", icyc_o, 0);
    check("adv_ack",  ack_o,  1);
    tick();
    check("adv_cstate", cstate_o, 3);

    // two wait states
    drive(1, 0, 0, 32'h0000_007F, 1);
    for (int i = 0; i < 2; i++) begin
      check("ws_icyc", icyc_o, 1);
      check("ws_ack",  ack_o,  0);
      tick();
      check("ws_cstate", cstate_o, 3);
      check("ws_pc",     iadr_o,   64'h104);
      check("ws_ir",     ir_o,     32'h0420_0093);
    end
    drive(1, 0, 1, 32'h0000_007F, 1);
    check("ws3_icyc", icyc_o, 1);
    check("ws3_ack",  ack_o,  1);
    tick();
    check("ws_ir_ld", ir_o,     32'h0000_007F);
    check("ws_ipc",   ipc_o,    64'h104);
    check("ws_pc_nx", iadr_o,   64'h108);
    check("ws_cst0",  cstate_o, 0);

    // illegal instruction; a jump in the same cycle must be ignored
    drive(0, 1, 0, 32'd0, 0);
    pc_ld_i = 1'b1; pc_dat_i = 64'h500; #1;
    check("ill_trap", trap_o, 1);
    tick();
    pc_ld_i = 1'b0;
    drive(0, 3, 0, 32'd0, 1);
    check("ill_trap_clr", trap_o,   0);
    check("ill_pc",       iadr_o,   64'h0);
    check("ill_epc",      epc_o,    64'h104);
    check("ill_cause",    cause_o,  2);
    check("ill_cstate",   cstate_o, 3);
    check("ill_ir",       ir_o,     32'h0000_0013);

    // misaligned fetch
    pc_ld_i = 1'b1; pc_dat_i = 64'h202;
    tick();
    pc_ld_i = 1'b0;
    check("mis_pcld", iadr_o, 64'h202);
    drive(1, 0, 1, 32'h1111_1111, 1);
    check("mis_icyc", icyc_o, 0);
    check("mis_trap", trap_o, 1);
    tick();
    drive(0, 3, 0, 32'd0, 1);
    check("mis_epc",    epc_o,    64'h202);
    check("mis_cause",  cause_o,  0);
    check("mis_pc",     iadr_o,   64'h0);
    check("mis_cstate", cstate_o, 3);
    check("mis_ir",     ir_o,     32'h0000_0013);

    // jump in the same cycle as fetch completion
    drive(1, 0, 1, 32'h0010_0113, 1);
    pc_ld_i = 1'b1; pc_dat_i = 64'h400;
    tick();
    pc_ld_i = 1'b0;
    drive(0, 3, 0, 32'd0, 1);
    check("jmp_pc",     iadr_o,   64'h400);
    check("jmp_ipc",    ipc_o,    64'h0);
    check("jmp_ir",     ir_o,     32'h0010_0113);
    check("jmp_cstate", cstate_o, 0);
    tick();

    // 64-bit wrap of pc+4
    pc_ld_i = 1'b1; pc_dat_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_ld_i = 1'b0;
    drive(1, 0, 1, 32'h0000_0013, 1);
    tick();
    drive(0, 3, 0, 32'd0, 1);
    check("wrap_pc",  iadr_o, 64'h0);
    check("wrap_ipc", ipc_o,  64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    // bus error at pc 0x300 (IR holds 0x13 from the wrap fetch)
    pc_ld_i = 1'b1; pc_dat_i = 64'h300;
    tick();
    pc_ld_i = 1'b0;
    ierr_i = 1'b1;
    drive(1, 0, 0, 32'h2222_2222, 1);
`ifdef FETCH_BUSERR_EN
    check("berr_trap", trap_o, 1);
    tick();
    ierr_i = 1'b0;
    drive(0, 3, 0, 32'd0, 1);
    check("berr_ir",     ir_o,     32'h0000_0013);
    check("berr_epc",    epc_o,    64'h300);
    check("berr_cause",  cause_o,  1);
    check("berr_pc",     iadr_o,   64'h0);
    check("berr_cstate", cstate_o, 3);
`else
    check("berr_trap", trap_o, 0);
    check("berr_icyc", icyc_o, 1);
    tick();
    check("berr_ir",     ir_o,     32'h0000_0013);
    check("berr_pc",     iadr_o,   64'h300);
    check("berr_cstate", cstate_o, 3);
    check("berr_epc",    epc_o,    64'h202);
    ierr_i = 1'b0;
`endif

    // asynchronous reset mid-fetch
    drive(1, 0, 0, 32'd0, 1);
    check("ar_icyc_pre", icyc_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("ar_icyc", icyc_o, 0);
    check("ar_istb", istb_o, 0);
    check("ar_pc",   iadr_o, 64'h100);
    check("ar_ir",   ir_o,   32'h0000_0013);
    tick();
    reset_i = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the decode_op_imm family of decoders.
- Owns the instruction fetch bus master, PC, IR and the 3-bit microcycle state register.
- Feeds ir_o, cstate_o, trap_o and ack_o to every decoder and consumes their nstate_i, ir_dat_irl_i and defined_i.
- Redirects to the trap vector on undefined instruction or misaligned fetch.

Parameters:
RESET_PC, 64'h0000_0000_0000_0100, PC value loaded on reset
TRAP_VECTOR, 64'h0000_0000_0000_0000, PC value loaded on any trap
NOP_IR, 32'h0000_0013, IR reset value (ADDI X0,X0,0)

Ports:
clk_i  in  1  clock; all state on rising edge
reset_i  in  1  asynchronous, active-high reset
iadr_o  out  64  fetch address (= pc during fetch)
icyc_o  out  1  fetch bus cycle active
istb_o  out  1  fetch strobe
iack_i  in  1  fetch acknowledge; idat_i valid
idat_i  in  32  fetched instruction word
ierr_i  in  1  bus error (used only with FETCH_BUSERR_EN)
ir_o  out  32  current instruction to decoders
cstate_o  out  3  current microcycle to decoders
nstate_i  in  3  next microcycle, OR of decoder outputs
ir_dat_irl_i  in  1  decoder requests IR load from idat_i
defined_i  in  1  OR of decoder defined_o
pc_ld_i  in  1  load PC from pc_dat_i (jumps/branches)
pc_dat_i  in  64  PC load value
ack_o  out  1  to decoders' ack_i
trap_o  out  1  one-cycle trap pulse; to decoders' trap_i
epc_o  out  64  address of the trapping instruction
cause_o  out  4  0 misaligned fetch, 1 fetch access fault, 2 illegal instruction
ipc_o  out  64  address of the instruction in ir_o

Behaviour:
- Reset values:
  - pc=RESET_PC, ipc_o=RESET_PC, ir_o=NOP_IR, cstate_o=3.
  - icyc_o=istb_o=0, trap_o=0, epc_o=0, cause_o=0.
  - The first clocks after reset therefore fetch via the NOP's cycle-3 request.
- Reset asserted mid-fetch drops icyc_o/istb_o immediately, asynchronously.
- fetch = ir_dat_irl_i && !trap_o && pc[1:0]==0.
  - During fetch: icyc_o=istb_o=1 and iadr_o=pc, combinational from state. Otherwise iadr_o=pc and icyc_o=istb_o=0.
- ack_o = fetch ? iack_i : 1.
- Stall: when fetch && !iack_i, cstate_o, ir_o, pc and ipc_o all hold. Wait states are unbounded.
- Fetch complete (fetch && iack_i):
  - ir_o<=idat_i, ipc_o<=pc, pc<=pc+4 (64-bit wrap), cstate_o<=nstate_i (decoders supply 0).
  - Zero-wait-state fetch takes 1 cycle; instruction latency is cycle-3 entry to cstate 0 in 1+N cycles for N wait states.
- Normal advance (no fetch, no trap): cstate_o<=nstate_i each clock.
- pc_ld_i: pc<=pc_dat_i. It outranks the pc+4 increment if both occur together.
- Illegal instruction trap (defined_i==0 in any cstate):
  - trap_o=1 combinationally.
  - Next edge: pc<=TRAP_VECTOR, epc_o<=ipc_o, cause_o<=2, ir_o<=NOP_IR, cstate_o<=3.
  - pc_ld_i is ignored that cycle.
- Misaligned fetch (ir_dat_irl_i && pc[1:0]!=0):
  - No bus cycle; trap_o=1.
  - epc_o<=pc, cause_o<=0, pc<=TRAP_VECTOR, ir_o<=NOP_IR, cstate_o<=3.
- Priority: reset > illegal trap > misaligned trap > bus error > pc_ld_i > fetch increment.
- trap_o is never high in two consecutive cycles unless the trap vector itself faults.

Optional Feature:
- Macro: FETCH_BUSERR_EN.
  - Defined: fetch && ierr_i is treated like a misaligned trap with cause_o<=1, epc_o<=pc. iack_i is ignored that cycle and IR is not loaded.
  - Undefined: ierr_i is unused and a fetch waits only on iack_i.

Decomposition:
- Shared package: cycle constants CYC_0..CYC_3, cause codes CAUSE_MISALIGN/CAUSE_ACCESS/CAUSE_ILLEGAL, NOP_IR encoding. Decoders reuse the cycle constants.
- One sub-module, fetch_pc_reg: PC register with load/increment/vector mux and misalignment flag.
- Trap and fetch control stay in the top level.

Test Plan:
- Reset, released at 0 wait states:
  - During reset: iadr_o=0x100, cstate_o=3, ir_o=0x00000013, icyc_o=0.
  - First clock with iack_i=1, idat_i=0x04200093: ir_o=0x04200093, ipc_o=0x100, pc=0x104, cstate_o=0.
- Two wait states:
  - icyc_o high for 3 cycles; cstate_o, pc, ir_o stable while iack_i=0.
  - Latch on the third cycle; ack_o mirrors iack_i.
- Illegal instruction: ir_o=0x0000007F at ipc 0x104, defined_i=0:
  - trap_o pulse.
  - Next cycle: pc=0, epc_o=0x104, cause_o=2, cstate_o=3, ir_o=NOP.
- Misaligned fetch: pc_ld_i with pc_dat_i=0x202, then fetch request:
  - icyc_o stays 0, trap_o=1, epc_o=0x202, cause_o=0, pc=0.
- Jump during fetch (pc_ld_i=1, pc_dat_i=0x400) in the same cycle as an iack_i completion:
  - pc=0x400, not pc+4; ipc_o=old pc.
- With FETCH_BUSERR_EN, ierr_i=1 at pc 0x300:
  - ir_o unchanged, epc_o=0x300, cause_o=1, pc=0.
  - Without the macro, the same stimulus with iack_i=0 just stalls.
